core: RTL and testbench

CORE -- requirements
Module: core

---
 rtl/core.sv | 188 ++++++++++++++++++
 tb/tb_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core.sv
// rtl/core.sv - 8-bit single-cycle core: 8-register bank, ALU with Z/C/N/V flags, PC with conditional branch.
// Register reads, ALU and branch decision are combinational from current state; all state updates on CLK.
module core (
   output logic [7:0] Addr,
   output logic [7:0] FLAGS,
   output logic [7:0] R0,
   output logic [7:0] R1,
   output logic [7:0] R2,
   output logic [7:0] R3,
   output logic [7:0] R4,
   output logic [7:0] R5,
   output logic [7:0] R6,
   output logic [7:0] R7,
   input  logic       MEM_INST,
   input  logic       ALU_INST,
   input  logic       JMP_INST,
   input  logic       MS1,
   input  logic       MS0,
   input  logic       IRS,
   input  logic       TR2,
   input  logic       TR1,
   input  logic       TR0,
   input  logic       AR2,
   input  logic       AR1,
   input  logic       AR0,
   input  logic       BS2,
   input  logic       BS1,
   input  logic       BS0,
   input  logic [3:0] OP,
   input  logic [7:0] IMM,
   input  logic       CLK,
   input  logic       RST
);

   logic [7:0] regs_q [8];
   logic [7:0] flags_q, flags_d;
   logic [7:0] addr_q, addr_d;

   logic [2:0] tr, ar, bs;
   logic [7:0] op_a, op_b;
   logic [7:0] res;
   logic       c_out, v_out;
   logic [8:0] wide;
   logic [7:0] wr_data;
   logic       take;
   logic       cin;

   assign tr   = {TR2, TR1, TR0};
   assign ar   = {AR2, AR1, AR0};
   assign bs   = {BS2, BS1, BS0};
   assign op_a = regs_q[ar];
   assign op_b = IRS ? IMM : regs_q[bs];
   assign cin  = flags_q[1];

   // Subtractions use a 9-bit difference so bit 8 is the borrow.
   always_comb begin
      wide  = 9'd0;
      res   = 8'h00;
      c_out = 1'b0;
      v_out = 1'b0;
      case (OP)
         4'h0: begin
            wide  = {1'b0, op_a} + {1'b0, op_b};
            res   = wide[7:0];
            c_out = wide[8];
            v_out = (op_a[7] == op_b[7]) && (res[7] != op_a[7]);
         end
         4'h1: begin
            wide  = {1'b0, op_a} + {1'b0, op_b} + {8'h00, cin};
            res   = wide[7:0];
            c_out = wide[8];
            v_out = (op_a[7] == op_b[7]) && (res[7] != op_a[7]);
         end
         4'h2: begin
            wide  = {1'b0, op_a} + 9'd1;
            res   = wide[7:0];
            c_out = wide[8];
         end
         4'h3: begin
            wide  = {1'b0, op_a} - 9'd1;
            res   = wide[7:0];
            c_out = wide[8];
         end
         4'h4: res = op_a & op_b;
         4'h5: res = op_a | op_b;
         4'h6: res = op_a ^ op_b;
         4'h7: res = op_b;
         4'h8: begin
            wide  = {1'b0, op_a} - {1'b0, op_b};
            res   = wide[7:0];
            c_out = wide[8];
            v_out = (op_a[7] != op_b[7]) && (res[7] != op_a[7]);
         end
         4'h9: begin
            wide  = {1'b0, op_a} - {1'b0, op_b} - {8'h00, cin};
            res   = wide[7:0];
            c_out = wide[8];
            v_out = (op_a[7] != op_b[7]) && (res[7] != op_a[7]);
         end
         4'hA: res = ~op_a;
         4'hB: begin
            wide  = 9'd0 - {1'b0, op_a};
            res   = wide[7:0];
            c_out = wide[8];
            v_out = (op_a == 8'h80);
         end
         4'hC: begin
            res   = {op_a[6:0], 1'b0};
            c_out = op_a[7];
         end
         4'hD: begin
            res   = {1'b0, op_a[7:1]};
            c_out = op_a[0];
         end
         4'hE: begin
            res   = {op_a[6:0], op_a[7]};
            c_out = op_a[7];
         end
         default: begin
            res   = {op_a[0], op_a[7:1]};
            c_out = op_a[0];
         end
      endcase
   end

   always_comb begin
      wr_data = 8'h00;
      case ({MS1, MS0})
         2'b00:   wr_data = res;
         2'b01:   wr_data = op_a;
         2'b10:   wr_data = IMM;
         default: wr_data = 8'h00;
      endcase
   end

   always_comb begin
      take = 1'b0;
      case (OP)
         4'h1:    take = flags_q[0];
         4'h2:    take = ~flags_q[0];
         4'h3:    take = ~flags_q[1];
         4'h4:    take = flags_q[1];
         4'h5:    take = flags_q[2];
         4'h6:    take = flags_q[3];
         4'h7:    take = 1'b1;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      addr_d = addr_q + 8'd1;
      if (JMP_INST && take) begin
         addr_d = IRS ? IMM : op_a;
      end
      flags_d = flags_q;
      if (ALU_INST) begin
         flags_d = {4'b0000, v_out, res[7], c_out, (res == 8'h00)};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q  <= 8'h00;
         flags_q <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         addr_q  <= addr_d;
         flags_q <= flags_d;
         if (MEM_INST) begin
            regs_q[tr] <= wr_data;
         end
      end
   end

   assign Addr  = addr_q;
   assign FLAGS = flags_q;
   assign R0    = regs_q[0];
   assign R1    = regs_q[1];
   assign R2    = regs_q[2];
   assign R3    = regs_q[3];
   assign R4    = regs_q[4];
   assign R5    = regs_q[5];
   assign R6    = regs_q[6];
   assign R7    = regs_q[7];

endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - directed self-checking bench for core.
module tb_core;

   logic       CLK;
   logic       RST;
   logic       MEM_INST, ALU_INST, JMP_INST;
   logic       MS1, MS0, IRS;
   logic       TR2, TR1, TR0, AR2, AR1, AR0, BS2, BS1, BS0;
   logic [3:0] OP;
   logic [7:0] IMM;
   logic [7:0] Addr, FLAGS;
   logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [7:0] rv [8];

   int checks;
   int errors;
   logic [7:0] exp_addr;

   core dut (
      .Addr(Addr), .FLAGS(FLAGS),
      .R0(r0), .R1(r1), .R2(r2), .R3(r3), .R4(r4), .R5(r5), .R6(r6), .R7(r7),
      .MEM_INST(MEM_INST), .ALU_INST(ALU_INST), .JMP_INST(JMP_INST),
      .MS1(MS1), .MS0(MS0), .IRS(IRS),
      .TR2(TR2), .TR1(TR1), .TR0(TR0),
      .AR2(AR2), .AR1(AR1), .AR0(AR0),
      .BS2(BS2), .BS1(BS1), .BS0(BS0),
      .OP(OP), .IMM(IMM), .CLK(CLK), .RST(RST)
   );

   always_comb begin
      rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
      rv[4] = r4; rv[5] = r5; rv[6] = r6; rv[7] = r7;
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic set_inst(input logic mem, input logic alu, input logic jmp,
                           input logic [1:0] ms, input logic irs,
                           input logic [2:0] tr, input logic [2:0] ar, input logic [2:0] bs,
                           input logic [3:0] op, input logic [7:0] imm);
      MEM_INST = mem; ALU_INST = alu; JMP_INST = jmp;
      {MS1, MS0} = ms; IRS = irs;
      {TR2, TR1, TR0} = tr; {AR2, AR1, AR0} = ar; {BS2, BS1, BS0} = bs;
      OP = op; IMM = imm;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      set_inst(0, 0, 0, 2'b00, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00);
      #2 RST = 1'b1;
      #1;
      checks++;
      if (Addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", Addr); end
      checks++;
      if (FLAGS !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", FLAGS); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rv[i] !== 8'h00) begin errors++; $display("FAIL reset_r%0d got %h exp 00", i, rv[i]); end
      end
      @(negedge CLK);
      #2 RST = 1'b0;
   endtask

   task automatic test_jmp_after_reset();
      set_inst(0, 0, 1, 2'b00, 0, 3'd0, 3'd0, 3'd0, 4'h7, 8'h00);
      tick();
      checks++;
      if (Addr !== 8'h00) begin errors++; $display("FAIL jmp_r0_addr got %h exp 00", Addr); end
      checks++;
      if (FLAGS !== 8'h00) begin errors++; $display("FAIL jmp_r0_flags got %h exp 00", FLAGS); end
   endtask

   task automatic test_load_imm();
      set_inst(1, 0, 0, 2'b10, 1, 3'd0, 3'd0, 3'd0, 4'h0, 8'd10);
      tick();
      checks++;
      if (r0 !== 8'd10) begin errors++; $display("FAIL load_r0 got %h exp 0a", r0); end
      checks++;
      if (Addr !== 8'd1) begin errors++; $display("FAIL load_addr1 got %h exp 01", Addr); end
      set_inst(1, 0, 0, 2'b10, 1, 3'd1, 3'd0, 3'd0, 4'h0, 8'd20);
      tick();
      checks++;
      if (r1 !== 8'd20) begin errors++; $display("FAIL load_r1 got %h exp 14", r1); end
      checks++;
      if (Addr !== 8'd2) begin errors++; $display("FAIL load_addr2 got %h exp 02", Addr); end
   endtask

   task automatic test_sub_flags();
      set_inst(0, 1, 0, 2'b00, 0, 3'd0, 3'd0, 3'd1, 4'h8, 8'h00);
      tick();
      checks++;
      if (FLAGS !== 8'b0000_0110) begin errors++; $display("FAIL sub_flags got %h exp 06", FLAGS); end
      checks++;
      if (r0 !== 8'd10 || r1 !== 8'd20) begin errors++; $display("FAIL sub_regs got %h %h exp 0a 14", r0, r1); end
      checks++;
      if (Addr !== 8'd3) begin errors++; $display("FAIL sub_addr got %h exp 03", Addr); end
   endtask

   task automatic test_branch();
      set_inst(0, 0, 1, 2'b00, 0, 3'd0, 3'd1, 3'd0, 4'h4, 8'h00);
      tick();
      checks++;
      if (Addr !== 8'd20) begin errors++; $display("FAIL br_c_taken got %h exp 14", Addr); end
      set_inst(0, 0, 1, 2'b00, 0, 3'd0, 3'd1, 3'd0, 4'h3, 8'h00);
      tick();
      checks++;
      if (Addr !== 8'd21) begin errors++; $display("FAIL br_nc_not_taken got %h exp 15", Addr); end
      set_inst(0, 0, 1, 2'b00, 1, 3'd0, 3'd1, 3'd0, 4'h8, 8'h99);
      tick();
      checks++;
      if (Addr !== 8'd22) begin errors++; $display("FAIL br_op8_never got %h exp 16", Addr); end
   endtask

   task automatic test_add_wrap();
      set_inst(1, 0, 0, 2'b10, 1, 3'd3, 3'd0, 3'd0, 4'h0, 8'd200);
      tick();
      set_inst(1, 0, 0, 2'b10, 1, 3'd4, 3'd0, 3'd0, 4'h0, 8'd100);
      tick();
      checks++;
      if (r3 !== 8'd200 || r4 !== 8'd100 || Addr !== 8'd24) begin
         errors++; $display("FAIL add_setup got %h %h %h exp c8 64 18", r3, r4, Addr);
      end
      set_inst(1, 1, 0, 2'b00, 0, 3'd2, 3'd3, 3'd4, 4'h0, 8'h00);
      tick();
      checks++;
      if (r2 !== 8'd44) begin errors++; $display("FAIL add_r2 got %h exp 2c", r2); end
      checks++;
      if (FLAGS !== 8'h02) begin errors++; $display("FAIL add_flags got %h exp 02", FLAGS); end
      set_inst(0, 0, 1, 2'b00, 1, 3'd0, 3'd0, 3'd0, 4'h7, 8'hFF);
      tick();
      checks++;
      if (Addr !== 8'hFF) begin errors++; $display("FAIL jmp_ff got %h exp ff", Addr); end
      set_inst(0, 0, 0, 2'b00, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00);
      tick();
      checks++;
      if (Addr !== 8'h00) begin errors++; $display("FAIL addr_wrap got %h exp 00", Addr); end
      exp_addr = 8'h00;
   endtask

   // {op, ar, imm, result, flags}; A = R3 = 0xC8 unless ar says otherwise, result lands in R5.
   task automatic test_alu_ops();
      logic [30:0] vecs [18];
      logic [3:0]  op;
      logic [2:0]  ar;
      logic [7:0]  imm, eres, efl;
      vecs = '{
         {4'h1, 3'd3, 8'h37, 8'h00, 8'h03},
         {4'h9, 3'd3, 8'h10, 8'hB7, 8'h04},
         {4'h2, 3'd3, 8'h00, 8'hC9, 8'h04},
         {4'h3, 3'd3, 8'h00, 8'hC7, 8'h04},
         {4'h4, 3'd3, 8'h0F, 8'h08, 8'h00},
         {4'h5, 3'd3, 8'h03, 8'hCB, 8'h04},
         {4'h6, 3'd3, 8'hC8, 8'h00, 8'h01},
         {4'h7, 3'd3, 8'h80, 8'h80, 8'h04},
         {4'h8, 3'd3, 8'h50, 8'h78, 8'h08},
         {4'hA, 3'd3, 8'h00, 8'h37, 8'h00},
         {4'hB, 3'd3, 8'h00, 8'h38, 8'h02},
         {4'hC, 3'd3, 8'h00, 8'h90, 8'h06},
         {4'hD, 3'd3, 8'h00, 8'h64, 8'h00},
         {4'hE, 3'd3, 8'h00, 8'h91, 8'h06},
         {4'hF, 3'd3, 8'h00, 8'h64, 8'h00},
         {4'h0, 3'd3, 8'h90, 8'h58, 8'h0A},
         {4'h3, 3'd6, 8'h00, 8'hFF, 8'h06},
         {4'h2, 3'd5, 8'h00, 8'h00, 8'h03}
      };
      for (int i = 0; i < 18; i++) begin
         {op, ar, imm, eres, efl} = vecs[i];
         set_inst(1, 1, 0, 2'b00, 1, 3'd5, ar, 3'd0, op, imm);
         tick();
         exp_addr = exp_addr + 8'd1;
         checks++;
         if (r5 !== eres) begin errors++; $display("FAIL alu_res[%0d] op %h got %h exp %h", i, op, r5, eres); end
         checks++;
         if (FLAGS !== efl) begin errors++; $display("FAIL alu_flags[%0d] op %h got %h exp %h", i, op, FLAGS, efl); end
         checks++;
         if (Addr !== exp_addr) begin errors++; $display("FAIL alu_addr[%0d] got %h exp %h", i, Addr, exp_addr); end
      end
   endtask

   task automatic test_same_cycle();
      set_inst(1, 1, 1, 2'b01, 1, 3'd7, 3'd1, 3'd0, 4'h7, 8'h40);
      tick();
      checks++;
      if (r7 !== 8'd20) begin errors++; $display("FAIL same_r7 got %h exp 14", r7); end
      checks++;
      if (FLAGS !== 8'h00) begin errors++; $display("FAIL same_flags got %h exp 00", FLAGS); end
      checks++;
      if (Addr !== 8'h40) begin errors++; $display("FAIL same_addr got %h exp 40", Addr); end
      set_inst(1, 0, 0, 2'b00, 0, 3'd1, 3'd1, 3'd0, 4'h2, 8'h00);
      tick();
      checks++;
      if (r1 !== 8'd21) begin errors++; $display("FAIL rmw_r1 got %h exp 15", r1); end
      checks++;
      if (FLAGS !== 8'h00) begin errors++; $display("FAIL flags_hold got %h exp 00", FLAGS); end
      set_inst(1, 0, 1, 2'b11, 1, 3'd1, 3'd0, 3'd0, 4'h1, 8'h10);
      tick();
      checks++;
      if (r1 !== 8'h00) begin errors++; $display("FAIL ms11_zero got %h exp 00", r1); end
      checks++;
      if (Addr !== 8'h42) begin errors++; $display("FAIL br_z_not_taken got %h exp 42", Addr); end
   endtask

   task automatic test_async_reset();
      set_inst(0, 0, 0, 2'b00, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      checks++;
      if (Addr !== 8'h00 || FLAGS !== 8'h00) begin
         errors++; $display("FAIL async_rst_addr_flags got %h %h exp 00 00", Addr, FLAGS);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rv[i] !== 8'h00) begin errors++; $display("FAIL async_rst_r%0d got %h exp 00", i, rv[i]); end
      end
      @(negedge CLK);
      RST = 1'b0;
      set_inst(1, 0, 0, 2'b10, 1, 3'd2, 3'd0, 3'd0, 4'h0, 8'h5A);
      tick();
      checks++;
      if (r2 !== 8'h5A || Addr !== 8'h01) begin
         errors++; $display("FAIL post_rst_exec got %h %h exp 5a 01", r2, Addr);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      exp_addr = 8'h00;
      RST      = 1'b0;
      test_reset();
      test_jmp_after_reset();
      test_load_imm();
      test_sub_flags();
      test_branch();
      test_add_wrap();
      test_alu_ops();
      test_same_cycle();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
